// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the sequencer state encoding and the nibble width.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/ripple_carry_adder_4_bit.sv
// Four-bit ripple carry adder built from a chain of full adders.
// Purely combinational; one instance is time-shared by the sequencer.
module ripple_carry_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [4:0] c;

    always_comb begin
        c[0] = carry_in;
        sum  = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carry_out = c[4];
    end

endmodule

// File: rtl/adder_sequencer.sv
// Wide adder that feeds one nibble per cycle through a single 4-bit
// ripple adder, carrying between nibbles through a register.
module adder_sequencer
    import adder_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / NIBBLE_W,
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    seq_state_t state, state_nxt;

    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic                carry_q;
    logic [IDX_W-1:0]    idx;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_co;
    logic                last;

    assign nib_a = a_q[NIBBLE_W*int'(idx) +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*int'(idx) +: NIBBLE_W];
    assign last  = (idx == IDX_W'(NIBBLES - 1));

    ripple_carry_adder_4_bit u_rca (
        .a         (nib_a),
        .b         (nib_b),
        .carry_in  (carry_q),
        .sum       (nib_sum),
        .carry_out (nib_co)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_carry;
                        idx     <= '0;
                        out_sum <= '0;
                    end
                end
                RUN: begin
                    out_sum[NIBBLE_W*int'(idx) +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_co;
                    // index holds on the final nibble so it never wraps
                    if (last) out_carry <= nib_co;
                    else      idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
// Scoreboard bench for adder_sequencer at WIDTH=16 and WIDTH=4.
// Expected sums are queued at accept and compared when DONE is seen.
module tb_adder_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        busy;

    logic       in_valid4;
    logic       in_ready4;
    logic [3:0] in_a4;
    logic [3:0] in_b4;
    logic       in_carry4;
    logic       out_valid4;
    logic       out_ready4;
    logic [3:0] out_sum4;
    logic       out_carry4;
    logic       busy4;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] sb_q[$];

    always #5 clk = ~clk;

    adder_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    adder_sequencer #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_a      (in_a4),
        .in_b      (in_b4),
        .in_carry  (in_carry4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_sum   (out_sum4),
        .out_carry (out_carry4),
        .busy      (busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic c);
        check("rdy_pre", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_carry = c;
        in_valid = 1'b1;
        sb_q.push_back({1'b0, a} + {1'b0, b} + 17'(c));
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        check("busy_run", 32'(busy), 32'd1);
        check("sum_clr", 32'(out_sum), 32'd0);
    endtask

    task automatic collect(input int hold);
        int          lat;
        logic [16:0] exp;
        logic [15:0] held;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        check("sum", 32'(out_sum), 32'(exp[15:0]));
        check("cout", 32'(out_carry), 32'(exp[16]));
        held = out_sum;
        for (int k = 0; k < hold; k++) begin
            in_valid = ~in_valid;
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            tick();
            check("hold_sum", 32'(out_sum), 32'(held));
            check("hold_cout", 32'(out_carry), 32'(exp[16]));
            check("hold_rdy", 32'(in_ready), 32'd0);
            check("hold_vld", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rdy_post", 32'(in_ready), 32'd1);
        check("vld_post", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          lat4;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_carry   = 1'b0;
        out_ready  = 1'b0;
        in_valid4  = 1'b0;
        in_a4      = '0;
        in_b4      = '0;
        in_carry4  = 1'b0;
        out_ready4 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_cout", 32'(out_carry), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        issue(16'h1234, 16'h1111, 1'b0);
        collect(0);
        issue(16'hFFFF, 16'h0001, 1'b0);
        collect(0);
        issue(16'hFFFF, 16'h0000, 1'b1);
        collect(0);
        issue(16'h8000, 16'h8000, 1'b0);
        collect(5);
        issue(16'h0102, 16'h0304, 1'b1);
        collect(0);

        issue(16'h0F0F, 16'h0101, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb_q.pop_back());
        check("mid_rdy", 32'(in_ready), 32'd1);
        check("mid_vld", 32'(out_valid), 32'd0);
        check("mid_sum", 32'(out_sum), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        issue(16'h0001, 16'h0001, 1'b0);
        collect(0);

        in_a4     = 4'hF;
        in_b4     = 4'h1;
        in_carry4 = 1'b1;
        in_valid4 = 1'b1;
        check("w4_rdy", 32'(in_ready4), 32'd1);
        tick();
        in_valid4 = 1'b0;
        lat4 = 0;
        while (!out_valid4 && lat4 < 10) begin
            tick();
            lat4++;
        end
        check("w4_lat", 32'(lat4), 32'd1);
        check("w4_sum", 32'(out_sum4), 32'h1);
        check("w4_cout", 32'(out_carry4), 32'd1);
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        check("w4_idle", 32'(in_ready4), 32'd1);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            issue(ra, rb, 1'($urandom));
            collect(0);
        end

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Multi-cycle controller that adds two WIDTH-bit operands by time-sharing a single `ripple_carry_adder_4_bit` instance. It processes one nibble per cycle, least-significant first, and carries between nibbles through a registered carry. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Use it where a wide combinational ripple chain is too slow or too large.

## Interface
Parameters:
- `WIDTH`, default 16: operand and sum width. Must be a multiple of 4 and ≥ 4.
- `NIBBLES`, derived, WIDTH/4: cycles spent in RUN per operation.

Ports:
- `clk` input 1: the single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: operands on `in_a`, `in_b` and `in_carry` are valid.
- `in_ready` output 1: block can accept operands. Driven combinationally as state==IDLE.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `in_carry` input 1: carry into nibble 0.
- `out_valid` output 1: `out_sum` and `out_carry` hold a completed result.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output WIDTH: (A + B + carry) mod 2^WIDTH.
- `out_carry` output 1: carry out of the most-significant nibble.
- `busy` output 1: high in RUN and DONE.

## Operation
The FSM has three states.
- IDLE: `in_ready`=1.
  - `in_valid`=1 at an edge: latch `in_a`, `in_b` into operand registers, load the carry register from `in_carry`, set nibble index to 0, clear `out_sum`. Go to RUN.
- RUN: the adder sees a[4i+3:4i], b[4i+3:4i] and the carry register, where i is the nibble index.
  - Each edge: write the adder sum to out_sum[4i+3:4i], load the carry register from the adder carry_out, increment the index.
  - When i==NIBBLES-1: also load `out_carry` from the adder carry_out and go to DONE.
- DONE: `out_valid`=1. `out_sum` and `out_carry` are held stable.
  - `out_ready`=1 at an edge: go to IDLE.
  - `out_ready`=0: stay in DONE indefinitely.

General rules:
- `in_valid` is ignored outside IDLE. Operands are never latched while busy.
- Latched operand registers are immune to changes on `in_a`/`in_b` after acceptance.
- The nibble index is ceil(log2(NIBBLES)) bits wide, with a minimum of 1. It never wraps: the exit condition is checked before increment.
- Reset values: state=IDLE, `out_valid`=0, `out_sum`=0, `out_carry`=0, carry register 0, index 0, `busy`=0. `in_ready` is 1 in the first cycle after reset deasserts.
- Reset mid-RUN or mid-DONE: the operation is abandoned and no result is presented. The next cycle is IDLE.
- Reset has priority over every handshake in the same cycle.

## Timing
- Accept edge: the edge with state=IDLE and `in_valid`=1. Call it edge 0.
- `out_valid` rises after edge NIBBLES, i.e. NIBBLES cycles of latency.
- Earliest next accept: the edge after the one where `out_ready`=1 is sampled in DONE. Minimum issue interval is NIBBLES+2 cycles.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.
- The ripple path is limited to 4 bits plus the nibble mux per cycle.
- WIDTH=4: one RUN cycle. `out_valid` is high after edge 1.

## Structure
- Shared package `adder_pkg` holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NIBBLE_W=4.
- One sub-module: the existing `ripple_carry_adder_4_bit`, instantiated once as `u_rca`. The sequencer supplies the nibble operand muxing and the carry register.
- No other hierarchy.

## Test plan
- WIDTH=16, A=0x1234, B=0x1111, cin=0 → `out_sum`=0x2345, `out_carry`=0. `out_valid` is first high 4 cycles after the accept edge.
- A=0xFFFF, B=0x0001, cin=0 → `out_sum`=0x0000, `out_carry`=1. Confirms the carry register propagates across all 4 nibbles.
- A=0xFFFF, B=0x0000, cin=1 → `out_sum`=0x0000, `out_carry`=1. A=0x8000, B=0x8000, cin=0 → `out_sum`=0x0000, `out_carry`=1.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` and changing `in_a`/`in_b` → result is unchanged, `in_ready`=0, nothing is accepted.
  - Then assert `out_ready` → IDLE on the next cycle. The new operand pair is accepted on the following edge.
- Assert `reset` for 1 cycle after 2 RUN edges of 0x0F0F+0x0101 → next cycle has state IDLE, `out_valid`=0, `out_sum`=0, `busy`=0. A fresh 0x0001+0x0001 then yields 0x0002.
- WIDTH=4, A=0xF, B=0x1, cin=1 → `out_sum`=0x1, `out_carry`=1, `out_valid` high after edge 1. A random sweep of 1000 pairs at WIDTH=16 matches the reference model A+B+cin.
